// File: rtl/fixed_multiply_pipe_if.sv
// Streaming handshake bundle for fixed_multiply_pipe: operand side (a/b/round_en)
// and result side (c/sat) with independent valid/ready pairs.
interface fixed_multiply_pipe_if #(
   parameter int operand_size = 32
);
   logic signed [operand_size-1:0] a;
   logic signed [operand_size-1:0] b;
   logic                           round_en;
   logic                           in_valid;
   logic                           in_ready;
   logic signed [operand_size-1:0] c;
   logic                           sat;
   logic                           out_valid;
   logic                           out_ready;

   modport master (
      output a, b, round_en, in_valid, out_ready,
      input  in_ready, c, sat, out_valid
   );

   modport slave (
      input  a, b, round_en, in_valid, out_ready,
      output in_ready, c, sat, out_valid
   );
endinterface

// File: rtl/fixed_multiply_pipe.sv
// Pipelined signed fixed-point multiplier: full-width product, optional round-half-up,
// arithmetic shift by the fraction width and saturation back to operand width.
module fixed_multiply_pipe #(
   parameter int fractional_size = 12,
   parameter int operand_size    = 32,
   parameter int pipeline_stages = 3
) (
   input logic                  clk,
   input logic                  rst,
   fixed_multiply_pipe_if.slave io
);
   localparam int W   = operand_size;
   localparam int PW  = 2 * W;
   localparam int RW  = PW + 1;
   localparam int DLY = (pipeline_stages > 2) ? pipeline_stages - 2 : 1;
   localparam int PDW = DLY * PW;

   localparam logic signed [RW-1:0] HALF  = (RW'(1) << fractional_size) >> 1;
   localparam logic signed [RW-1:0] MAX_V = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

   logic                  adv;
   logic signed [W-1:0]   a_q, a_d, b_q, b_d;
   logic                  rnd1_q, rnd1_d, vld1_q, vld1_d;
   logic signed [PW-1:0]  prod;
   logic signed [PW-1:0]  fin_p;
   logic                  fin_rnd, fin_vld;
   logic signed [RW-1:0]  r_val, s_val;
   logic signed [W-1:0]   c_q, c_d;
   logic                  sat_q, sat_d, ov_q, ov_d;

   assign adv          = !ov_q || io.out_ready;
   assign io.in_ready  = adv;
   assign io.c         = c_q;
   assign io.sat       = sat_q;
   assign io.out_valid = ov_q;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      rnd1_d = rnd1_q;
      vld1_d = vld1_q;
      if (adv) begin
         a_d    = io.a;
         b_d    = io.b;
         rnd1_d = io.round_en;
         vld1_d = io.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         rnd1_q <= 1'b0;
         vld1_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         rnd1_q <= rnd1_d;
         vld1_q <= vld1_d;
      end
   end

   // Low PW bits of the sign-extended product are the exact signed product.
   always_comb prod = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};

   generate
      if (pipeline_stages == 2) begin : g_merged
         assign fin_p   = prod;
         assign fin_rnd = rnd1_q;
         assign fin_vld = vld1_q;
      end else begin : g_delay
         logic [DLY-1:0][PW-1:0] p_q, p_d;
         logic [DLY-1:0]         rnd_q, rnd_d, vld_q, vld_d;

         // Shift-in at index 0; the oldest entry falls off the top via the cast.
         always_comb begin
            p_d   = p_q;
            rnd_d = rnd_q;
            vld_d = vld_q;
            if (adv) begin
               p_d   = PDW'({p_q, prod});
               rnd_d = DLY'({rnd_q, rnd1_q});
               vld_d = DLY'({vld_q, vld1_q});
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               p_q   <= '0;
               rnd_q <= '0;
               vld_q <= '0;
            end else begin
               p_q   <= p_d;
               rnd_q <= rnd_d;
               vld_q <= vld_d;
            end
         end

         assign fin_p   = p_q[DLY-1];
         assign fin_rnd = rnd_q[DLY-1];
         assign fin_vld = vld_q[DLY-1];
      end
   endgenerate

   always_comb begin
      r_val = {fin_p[PW-1], fin_p} + (fin_rnd ? HALF : '0);
      s_val = r_val >>> fractional_size;
      c_d   = c_q;
      sat_d = sat_q;
      ov_d  = ov_q;
      if (adv) begin
         ov_d = fin_vld;
         if (s_val > MAX_V) begin
            c_d   = {1'b0, {(W - 1){1'b1}}};
            sat_d = 1'b1;
         end else if (s_val < MIN_V) begin
            c_d   = {1'b1, {(W - 1){1'b0}}};
            sat_d = 1'b1;
         end else begin
            c_d   = s_val[W-1:0];
            sat_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q   <= '0;
         sat_q <= 1'b0;
         ov_q  <= 1'b0;
      end else begin
         c_q   <= c_d;
         sat_q <= sat_d;
         ov_q  <= ov_d;
      end
   end
endmodule
